// File: rtl/demux_reg_router.sv
// demux_reg_router: routes a word to one of 2**ADR_W channels (or all, on broadcast),
// holding it in a per-channel one-entry register under valid/ready handshakes.
module demux_reg_router #(
    parameter int DATA_W = 8,
    parameter int ADR_W  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [ADR_W-1:0]            in_adr,
    input  logic                        in_bcast,
    output logic [2**ADR_W-1:0]         out_valid,
    input  logic [2**ADR_W-1:0]         out_ready,
    output logic [2**ADR_W*DATA_W-1:0]  out_data,
    output logic [ADR_W:0]              occ
);
    localparam int N = 2**ADR_W;

    logic [N-1:0]             free, load, valid_nxt;
    logic [N-1:0][DATA_W-1:0] data_q;
    logic [ADR_W:0]           cnt_nxt;

    // a full channel whose consumer is taking its word can be reloaded on the same edge
    assign free     = ~out_valid | out_ready;
    assign in_ready = in_bcast ? &free : free[in_adr];
    assign out_data = data_q;

    always_comb begin
        load = '0;
        if (in_valid && in_ready)
            load = in_bcast ? {N{1'b1}} : {{(N-1){1'b0}}, 1'b1} << in_adr;
        valid_nxt = load | (out_valid & ~out_ready);
        cnt_nxt = '0;
        for (int i = 0; i < N; i++)
            cnt_nxt = cnt_nxt + {{ADR_W{1'b0}}, valid_nxt[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            occ       <= '0;
            data_q    <= '0;
        end else begin
            out_valid <= valid_nxt;
            occ       <= cnt_nxt;
            for (int k = 0; k < N; k++)
                if (load[k]) data_q[k] <= in_data;
        end
    end
endmodule

// File: tb/tb_demux_reg_router.sv
// tb_demux_reg_router: directed-vector bench for demux_reg_router (DATA_W=8, ADR_W=3).
module tb_demux_reg_router;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [2:0]  in_adr = '0;
    logic        in_bcast = 1'b0;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready = '0;
    logic [63:0] out_data;
    logic [3:0]  occ;
    int total = 0;
    int bad = 0;

    demux_reg_router #(.DATA_W(8), .ADR_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_adr(in_adr), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        chk("rst_valid", out_valid, 8'h00);
        chk("rst_occ", occ, 0);
        chk("rst_ready", in_ready, 1);
        // fill channels 2 and 5, then reset asynchronously mid-cycle
        in_valid = 1'b1; in_adr = 3'd2; in_data = 8'h22;
        tick();
        in_adr = 3'd5; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        chk("pre_valid", out_valid, 8'h24);
        chk("pre_occ", occ, 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 8'h00);
        chk("arst_occ", occ, 0);
        chk("arst_data", out_data, 64'h0);
        chk("arst_ready", in_ready, 1);
        @(negedge clk) rst = 1'b0;
        // sweep
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_adr = 3'(k); in_data = 8'hA0 + 8'(k);
            #1 chk("sweep_ready", in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk("sweep_valid", out_valid, 8'hFF >> (7 - k));
            chk("sweep_occ", occ, k + 1);
        end
        for (int k = 0; k < 8; k++)
            chk("sweep_data", out_data[k*8 +: 8], 8'hA0 + 8'(k));
        // backpressure on channel 3
        in_valid = 1'b1; in_adr = 3'd3; in_data = 8'h55;
        #1 chk("bp_ready", in_ready, 0);
        tick();
        chk("bp_hold", out_data[24 +: 8], 8'hA3);
        chk("bp_valid", out_valid, 8'hFF);
        out_ready = 8'h08;
        #1 chk("bp_ready2", in_ready, 1);
        tick();
        in_valid = 1'b0; out_ready = '0;
        chk("dl_valid", out_valid, 8'hFF);
        chk("dl_data", out_data[24 +: 8], 8'h55);
        chk("dl_occ", occ, 8);
        // independence: free channel 6, load it while channel 3 stays blocked
        out_ready = 8'h40;
        tick();
        out_ready = '0;
        chk("ind_drain", out_valid, 8'hBF);
        chk("ind_occ0", occ, 7);
        in_valid = 1'b1; in_adr = 3'd6; in_data = 8'h66;
        #1 chk("ind_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("ind_data", out_data[48 +: 8], 8'h66);
        chk("ind_occ", occ, 8);
        chk("ind_valid", out_valid, 8'hFF);
        // broadcast blocked by channel 1, then accepted
        out_ready = 8'hFD;
        tick();
        out_ready = '0;
        chk("bc_pre", out_valid, 8'h02);
        in_valid = 1'b1; in_bcast = 1'b1; in_data = 8'hFF;
        #1 chk("bc_block", in_ready, 0);
        tick();
        chk("bc_nochg", out_valid, 8'h02);
        chk("bc_occ0", occ, 1);
        chk("bc_data0", out_data[7:0], 8'hA0);
        out_ready = 8'h02;
        #1 chk("bc_ready", in_ready, 1);
        tick();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
        chk("bc_valid", out_valid, 8'hFF);
        chk("bc_data", out_data, {64{1'b1}});
        chk("bc_occ", occ, 8);
        // partial drain
        out_ready = 8'b1010_0101;
        tick();
        out_ready = '0;
        chk("dr_valid", out_valid, 8'b0101_1010);
        chk("dr_occ", occ, 4);
        chk("dr_data", out_data, {64{1'b1}});
        // ready on an empty channel does nothing
        out_ready = 8'h01;
        tick();
        out_ready = '0;
        chk("idle_ready", out_valid, 8'b0101_1010);
        chk("idle_occ", occ, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_reg_router.md
# demux_reg_router

Parametrised, registered successor to the 1-to-8 combinational demux. Routes a DATA_W-bit word to one of 2**ADR_W output channels selected by an address, and holds it in a per-channel one-entry register until that channel consumes it. Uses a valid/ready handshake on the input side and on every output channel. Also supports a broadcast mode that loads all channels at once. Sits between the memory write-side control and the 8x8 memory row/bank buffers; its outputs drive the tri-state buffer enables and data.

## Interface
- DATA_W, 8, width of the routed word
- ADR_W, 3, address width; channel count N = 2**ADR_W
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the word this cycle (combinational)
- in_data  input  DATA_W  word to route
- in_adr  input  ADR_W  destination channel, ignored when in_bcast=1
- in_bcast  input  1  broadcast: load in_data into all N channels
- out_valid  output  N  bit k: channel k holds a word
- out_ready  input  N  bit k: consumer of channel k takes the word this cycle
- out_data  output  N*DATA_W  channel k word on bits [k*DATA_W +: DATA_W]
- occ  output  ADR_W+1  number of channels with out_valid set, 0..N

## Operation
- Channel k is free when out_valid[k]=0 or out_ready[k]=1, because a drain and a load may happen in the same cycle.
- in_ready for a unicast word (in_bcast=0) = free(in_adr).
- in_ready for a broadcast word (in_bcast=1) = AND of free(k) over all k. Broadcast is all-or-nothing; there are no partial loads.
- A transfer happens on an edge with in_valid & in_ready.
  - Unicast: out_data[in_adr] <= in_data and out_valid[in_adr] <= 1.
  - Broadcast: every channel loads in_data and every out_valid bit is set.
- A drain happens on an edge with out_valid[k] & out_ready[k]: out_valid[k] <= 0, unless the same edge loads channel k.
- Drain and load on the same channel in the same edge: out_valid stays 1 and the data is replaced by the new word.
- out_ready[k] while out_valid[k]=0 has no effect.
- in_adr/in_data/in_bcast are sampled only on a transfer edge. With in_valid=0 they are don't-care.
- out_data[k] holds its last loaded value after a drain; it is not cleared.
- Channels are independent. Draining one channel never blocks a unicast to another.
- occ is registered and equals popcount(out_valid) at all times.
- Rules for in_valid (not checked by the block):
  - No combinational path from in_ready to in_valid.
  - Once raised, in_valid stays high with stable data/adr until the transfer.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - out_valid=0, out_data=0, occ=0.
  - in_ready=1 for any request, since all channels are free.
- Latency: a word accepted on edge t is visible on out_valid/out_data after edge t, i.e. one cycle.
- Throughput: one word per cycle per channel when the consumer holds out_ready=1 continuously.
- Combinational paths:
  - in_ready depends combinationally on in_adr, in_bcast, out_valid and out_ready.
  - No combinational path from in_* to out_* or occ.
- Reset asserted mid-transfer clears all channels immediately, regardless of clk. A word presented in that cycle is lost.
- occ update per edge is +loads − drains. Examples:
  - Unicast to an empty channel: +1.
  - Broadcast with 3 draining and 5 empty: goes to N.
  - Load and drain on the same channel: 0.

## Test plan
All scenarios use DATA_W=8, ADR_W=3.

- Reset: assert rst mid-cycle with channels 2 and 5 full.
  - Required: out_valid=8'h00, occ=0 and all out_data=0 without waiting for a clk edge; in_ready=1.
- Sweep: send unicast words 8'hA0+k to adr k=0..7 with out_ready=0.
  - Required: out_valid=8'h01,8'h03,…,8'hFF one cycle after each transfer; occ increments 1..8; channel k data=8'hA0+k.
- Backpressure: channel 3 full, out_ready[3]=0, present adr=3, data 8'h55.
  - Required: in_ready=0, channel 3 keeps its old word.
  - Then raise out_ready[3]: same-edge drain+load, out_valid[3] stays 1, data becomes 8'h55, occ unchanged.
- Independence: channel 3 blocked, present adr=6, data 8'h66.
  - Required: in_ready=1, channel 6 loaded next cycle, occ+1.
- Broadcast, blocked then accepted: in_bcast=1, data 8'hFF, channel 1 full and not ready.
  - Required: in_ready=0 and no channel changes.
  - Then out_ready[1]=1: all out_valid=8'hFF, all data=8'hFF, occ=8.
- Drain: with all channels full, pulse out_ready=8'b1010_0101 for one cycle.
  - Required: out_valid=8'b0101_1010, occ=4, out_data unchanged.
